gpio_ctrl: RTL and testbench



---
 rtl/gpio_pkg.sv | 34 +++
 rtl/gpio_in_filter.sv | 56 +++++
 rtl/gpio_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_gpio_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// rtl/gpio_pkg.sv - shared register map, bank sizing and bus bundle types for gpio_ctrl
package gpio_pkg;

    localparam int GPIO_BANK_W = 32;

    localparam logic [7:0] GPIO_DIR_OFFS     = 8'h00;
    localparam logic [7:0] GPIO_OUT_OFFS     = 8'h10;
    localparam logic [7:0] GPIO_OUT_SET_OFFS = 8'h20;
    localparam logic [7:0] GPIO_OUT_CLR_OFFS = 8'h30;
    localparam logic [7:0] GPIO_OUT_TGL_OFFS = 8'h40;
    localparam logic [7:0] GPIO_IN_OFFS      = 8'h50;
    localparam logic [7:0] GPIO_RISE_EN_OFFS = 8'h60;
    localparam logic [7:0] GPIO_FALL_EN_OFFS = 8'h70;
    localparam logic [7:0] GPIO_STATUS_OFFS  = 8'h80;
    localparam logic [7:0] GPIO_DEB_EN_OFFS  = 8'h90;
    localparam logic [7:0] GPIO_DEB_DIV_OFFS = 8'hA0;

    function automatic int gpio_num_banks(input int n);
        return (n + GPIO_BANK_W - 1) / GPIO_BANK_W;
    endfunction

    typedef struct packed {
        logic        req;
        logic        we;
        logic [7:0]  addr;
        logic [31:0] wdata;
    } gpio_reg_req_t;

    typedef struct packed {
        logic        rvalid;
        logic [31:0] rdata;
    } gpio_reg_rsp_t;

endpackage

// File: rtl/gpio_in_filter.sv
// rtl/gpio_in_filter.sv - one-channel input synchroniser, tick-based debounce and edge detect
module gpio_in_filter #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic pad_i,
    input  logic tick_i,
    input  logic deb_en_i,
    output logic filt_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   smp_q, smp_d;
    logic                   filt_q, filt_d;
    logic                   prev_q;
    logic                   sync;

    assign sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], pad_i};
        smp_d  = smp_q;
        filt_d = filt_q;
        if (tick_i) begin
            smp_d = sync;
        end
        // Debounced level only moves when two consecutive ticks agree.
        if (!deb_en_i) begin
            filt_d = sync;
        end else if (tick_i && (sync == smp_q)) begin
            filt_d = sync;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q <= '0;
            smp_q  <= 1'b0;
            filt_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            smp_q  <= smp_d;
            filt_q <= filt_d;
            prev_q <= filt_q;
        end
    end

    assign filt_o = filt_q;
    assign rise_o = filt_q & ~prev_q;
    assign fall_o = ~filt_q & prev_q;

endmodule

// File: rtl/gpio_ctrl.sv
// rtl/gpio_ctrl.sv - banked GPIO controller: register file, atomic output ops, debounce ticks, edge irqs
module gpio_ctrl
    import gpio_pkg::*;
#(
    parameter int NUM_GPIO    = 62,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_DIV_W   = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                reg_req_i,
    input  logic                reg_we_i,
    input  logic [7:0]          reg_addr_i,
    input  logic [31:0]         reg_wdata_i,
    output logic                reg_rvalid_o,
    output logic [31:0]         reg_rdata_o,
    input  logic [NUM_GPIO-1:0] gpio_in_i,
    output logic [NUM_GPIO-1:0] gpio_out_o,
    output logic [NUM_GPIO-1:0] gpio_dir_o,
    output logic [NUM_GPIO-1:0] irq_vec_o,
    output logic                irq_o
);

    localparam int NB = gpio_num_banks(NUM_GPIO);
    localparam int PW = NB * GPIO_BANK_W;

    logic [NUM_GPIO-1:0]  dir_q, dir_d;
    logic [NUM_GPIO-1:0]  out_q, out_d;
    logic [NUM_GPIO-1:0]  rise_en_q, rise_en_d;
    logic [NUM_GPIO-1:0]  fall_en_q, fall_en_d;
    logic [NUM_GPIO-1:0]  status_q, status_d;
    logic [NUM_GPIO-1:0]  deb_en_q, deb_en_d;
    logic [DEB_DIV_W-1:0] deb_div_q, deb_div_d;
    logic [DEB_DIV_W-1:0] tick_cnt_q, tick_cnt_d;
    logic                 rvalid_q;
    logic [31:0]          rdata_q, rdata_d;
    logic                 irq_q;

    logic [NUM_GPIO-1:0]  filt, rise_raw, fall_raw, edge_evt;
    logic [NUM_GPIO-1:0]  wmask, wbits, status_clr, rd_vec;
    logic [PW-1:0]        rd_full;
    logic [7:0]           reg_off;
    logic [1:0]           bank;
    logic                 wr, rd, div_wr, tick;
    logic                 unused_addr_bits;

    assign reg_off          = {reg_addr_i[7:4], 4'b0000};
    assign bank             = reg_addr_i[3:2];
    assign wr               = reg_req_i & reg_we_i;
    assign rd               = reg_req_i & ~reg_we_i;
    assign unused_addr_bits = ^reg_addr_i[1:0];

    // Write data lands only on channels of the addressed bank; out-of-range banks match nothing.
    always_comb begin
        wmask = '0;
        wbits = '0;
        for (int i = 0; i < NUM_GPIO; i++) begin
            if (bank == 2'(i / GPIO_BANK_W)) begin
                wmask[i] = 1'b1;
                wbits[i] = reg_wdata_i[i % GPIO_BANK_W];
            end
        end
    end

    always_comb begin
        dir_d      = dir_q;
        out_d      = out_q;
        rise_en_d  = rise_en_q;
        fall_en_d  = fall_en_q;
        deb_en_d   = deb_en_q;
        deb_div_d  = deb_div_q;
        div_wr     = 1'b0;
        status_clr = '0;
        if (wr) begin
            case (reg_off)
                GPIO_DIR_OFFS:     dir_d     = (dir_q & ~wmask) | wbits;
                GPIO_OUT_OFFS:     out_d     = (out_q & ~wmask) | wbits;
                GPIO_OUT_SET_OFFS: out_d     = out_q | wbits;
                GPIO_OUT_CLR_OFFS: out_d     = out_q & ~wbits;
                GPIO_OUT_TGL_OFFS: out_d     = out_q ^ wbits;
                GPIO_RISE_EN_OFFS: rise_en_d = (rise_en_q & ~wmask) | wbits;
                GPIO_FALL_EN_OFFS: fall_en_d = (fall_en_q & ~wmask) | wbits;
                GPIO_STATUS_OFFS:  status_clr = wbits;
                GPIO_DEB_EN_OFFS:  deb_en_d  = (deb_en_q & ~wmask) | wbits;
                GPIO_DEB_DIV_OFFS: begin
                    if (bank == 2'd0) begin
                        deb_div_d = reg_wdata_i[DEB_DIV_W-1:0];
                        div_wr    = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // A fresh edge beats a simultaneous W1C so no event is ever lost.
    assign edge_evt = (rise_raw & rise_en_q) | (fall_raw & fall_en_q);
    assign status_d = (status_q & ~status_clr) | edge_evt;

    assign tick = (tick_cnt_q == deb_div_q);

    always_comb begin
        if (div_wr || tick) begin
            tick_cnt_d = '0;
        end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
        end
    end

    always_comb begin
        case (reg_off)
            GPIO_DIR_OFFS:     rd_vec = dir_q;
            GPIO_OUT_OFFS:     rd_vec = out_q;
            GPIO_IN_OFFS:      rd_vec = filt;
            GPIO_RISE_EN_OFFS: rd_vec = rise_en_q;
            GPIO_FALL_EN_OFFS: rd_vec = fall_en_q;
            GPIO_STATUS_OFFS:  rd_vec = status_q;
            GPIO_DEB_EN_OFFS:  rd_vec = deb_en_q;
            default:           rd_vec = '0;
        endcase
    end

    assign rd_full = PW'(rd_vec);

    always_comb begin
        rdata_d = '0;
        if (rd) begin
            if (reg_off == GPIO_DEB_DIV_OFFS) begin
                if (bank == 2'd0) begin
                    rdata_d = 32'(deb_div_q);
                end
            end else begin
                for (int b = 0; b < NB; b++) begin
                    if (bank == 2'(b)) begin
                        rdata_d = rd_full[b*GPIO_BANK_W +: GPIO_BANK_W];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            dir_q      <= '0;
            out_q      <= '0;
            rise_en_q  <= '0;
            fall_en_q  <= '0;
            status_q   <= '0;
            deb_en_q   <= '0;
            deb_div_q  <= '0;
            tick_cnt_q <= '0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            irq_q      <= 1'b0;
        end else begin
            dir_q      <= dir_d;
            out_q      <= out_d;
            rise_en_q  <= rise_en_d;
            fall_en_q  <= fall_en_d;
            status_q   <= status_d;
            deb_en_q   <= deb_en_d;
            deb_div_q  <= deb_div_d;
            tick_cnt_q <= tick_cnt_d;
            rvalid_q   <= reg_req_i;
            rdata_q    <= rdata_d;
            irq_q      <= |status_d;
        end
    end

    for (genvar g = 0; g < NUM_GPIO; g++) begin : g_ch
        gpio_in_filter #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_filt (
            .clk_i    (clk_i),
            .rst_ni   (rst_ni),
            .pad_i    (gpio_in_i[g]),
            .tick_i   (tick),
            .deb_en_i (deb_en_q[g]),
            .filt_o   (filt[g]),
            .rise_o   (rise_raw[g]),
            .fall_o   (fall_raw[g])
        );
    end

    assign reg_rvalid_o = rvalid_q;
    assign reg_rdata_o  = rdata_q;
    assign gpio_out_o   = out_q;
    assign gpio_dir_o   = dir_q;
    assign irq_vec_o    = status_q;
    assign irq_o        = irq_q;

endmodule

// File: tb/tb_gpio_ctrl.sv
// tb/tb_gpio_ctrl.sv - directed-vector bench with response scoreboard for gpio_ctrl
module tb_gpio_ctrl;

    localparam int N = 62;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req, we;
    logic [7:0]    addr;
    logic [31:0]   wdata;
    logic          rvalid;
    logic [31:0]   rdata;
    logic [N-1:0]  gpio_in, gpio_out, gpio_dir, irq_vec;
    logic          irq;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        logic [7:0]  a;
        logic [31:0] exp;
        int          c;
    } item_t;

    item_t sb[$];

    gpio_ctrl #(.NUM_GPIO(N), .SYNC_STAGES(2), .DEB_DIV_W(16)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .reg_req_i    (req),
        .reg_we_i     (we),
        .reg_addr_i   (addr),
        .reg_wdata_i  (wdata),
        .reg_rvalid_o (rvalid),
        .reg_rdata_o  (rdata),
        .gpio_in_i    (gpio_in),
        .gpio_out_o   (gpio_out),
        .gpio_dir_o   (gpio_dir),
        .irq_vec_o    (irq_vec),
        .irq_o        (irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Every request expects exactly one rvalid one cycle later.
    always @(negedge clk) begin
        if (rvalid) begin
            if (sb.size() == 0) begin
                chk("unexpected_rvalid", 1, 0);
            end else begin
                item_t it;
                it = sb.pop_front();
                chk($sformatf("rdata@%02h", it.a), rdata, it.exp);
                chk($sformatf("rvalid_lat@%02h", it.a), cyc, it.c + 1);
            end
        end
    end

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        item_t it;
        it.a = a; it.exp = 32'h0; it.c = cyc;
        sb.push_back(it);
        req = 1'b1; we = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        req = 1'b0; we = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, input logic [31:0] e);
        item_t it;
        it.a = a; it.exp = e; it.c = cyc;
        sb.push_back(it);
        req = 1'b1; we = 1'b0; addr = a; wdata = 32'h0;
        @(negedge clk);
        req = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; gpio_in = '0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        chk("rst_out", gpio_out, 0);
        chk("rst_dir", gpio_dir, 0);
        chk("rst_irqvec", irq_vec, 0);
        chk("rst_irq", irq, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rdata", rdata, 0);

        for (int b = 0; b < 2; b++)
            for (int r = 0; r < 10; r++)
                rd(8'(r * 16 + b * 4), 32'h0);
        rd(8'hA0, 32'h0);

        wr(8'h00, 32'hFFFF_0000);
        chk("dir0_pin", gpio_dir[31:0], 32'hFFFF_0000);
        wr(8'h10, 32'h0000_00FF);
        chk("out_wr_pin", gpio_out[31:0], 32'h0000_00FF);
        wr(8'h20, 32'h0000_0100);
        chk("out_set_pin", gpio_out[31:0], 32'h0000_01FF);
        wr(8'h30, 32'h0000_0001);
        chk("out_clr_pin", gpio_out[31:0], 32'h0000_01FE);
        wr(8'h40, 32'h0000_0003);
        chk("out_tgl_pin", gpio_out[31:0], 32'h0000_01FD);
        rd(8'h10, 32'h0000_01FD);
        rd(8'h00, 32'hFFFF_0000);
        rd(8'h20, 32'h0);
        rd(8'h40, 32'h0);

        wr(8'h60, 32'h0000_0020);
        gpio_in[5] = 1'b1;
        repeat (2) @(negedge clk);
        chk("irq_pre", irq, 0);
        rd(8'h50, 32'h0);
        chk("irq_t3", irq, 0);
        rd(8'h50, 32'h0000_0020);
        chk("irq_t4", irq, 1);
        chk("irqvec_t4", irq_vec[31:0], 32'h20);
        rd(8'h80, 32'h0000_0020);
        wr(8'h80, 32'h0000_0020);
        chk("irq_w1c", irq, 0);
        rd(8'h80, 32'h0);

        gpio_in[61] = 1'b1;
        repeat (5) @(negedge clk);
        wr(8'h74, 32'hFFFF_FFFF);
        rd(8'h74, 32'h3FFF_FFFF);
        gpio_in[61] = 1'b0;
        repeat (6) @(negedge clk);
        rd(8'h84, 32'h2000_0000);
        chk("irqvec61", irq_vec[61], 1);
        chk("irq_fall", irq, 1);
        wr(8'h84, 32'hFFFF_FFFF);
        chk("irq_fall_clr", irq, 0);
        wr(8'h04, 32'hFFFF_FFFF);
        chk("dir_hi_pin", gpio_dir[61:32], 30'h3FFF_FFFF);
        rd(8'h04, 32'h3FFF_FFFF);
        wr(8'h08, 32'hFFFF_FFFF);
        rd(8'h08, 32'h0);
        rd(8'h58, 32'h0);
        rd(8'hB0, 32'h0);
        rd(8'hA4, 32'h0);

        wr(8'h60, 32'h0000_0021);
        wr(8'hA0, 32'h0000_0009);
        wr(8'h90, 32'h0000_0001);
        rd(8'hA0, 32'h0000_0009);
        rd(8'h90, 32'h0000_0001);
        gpio_in[0] = 1'b1;
        repeat (5) @(negedge clk);
        gpio_in[0] = 1'b0;
        repeat (30) @(negedge clk);
        rd(8'h50, 32'h0000_0020);
        rd(8'h80, 32'h0);
        gpio_in[0] = 1'b1;
        repeat (23) @(negedge clk);
        rd(8'h50, 32'h0000_0021);
        rd(8'h80, 32'h0000_0001);
        wr(8'h80, 32'h0000_0001);

        wr(8'h60, 32'h0000_0029);
        gpio_in[3] = 1'b1;
        repeat (3) @(negedge clk);
        wr(8'h80, 32'h0000_0008);
        chk("set_wins", irq_vec[3], 1);
        rd(8'h80, 32'h0000_0008);
        wr(8'h80, 32'h0000_0008);
        rd(8'h80, 32'h0);
        @(negedge clk);

        rst_n = 1'b0; req = 1'b1; we = 1'b0; addr = 8'h50;
        @(negedge clk);
        rst_n = 1'b1; req = 1'b0;
        chk("rstmid_rvalid", rvalid, 0);
        chk("rstmid_out", gpio_out, 0);
        chk("rstmid_dir", gpio_dir, 0);
        chk("rstmid_irqvec", irq_vec, 0);
        chk("rstmid_irq", irq, 0);
        @(negedge clk);
        chk("rstmid_rvalid2", rvalid, 0);
        rd(8'hA0, 32'h0);
        rd(8'h60, 32'h0);

        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
